// File: rtl/quad_enc_gen.sv
// Quadrature encoder signal generator: turns step commands into A/B/Z edges at a
// programmable quarter-period while tracking a signed position and revolution index.
module quad_enc_gen #(
  parameter int STEP_W = 16,
  parameter int PRD_W  = 16,
  parameter int POS_W  = 32,
  parameter int PPR    = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_ccw,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [PRD_W-1:0]  cmd_qprd,
  input  logic              abort,
  output logic              enc_a,
  output logic              enc_b,
  output logic              enc_z,
  output logic [POS_W-1:0]  pos,
  output logic              busy,
  output logic              done
);

  localparam int REV_N = 4 * PPR;
  localparam int REV_W = (REV_N > 2) ? $clog2(REV_N) : 1;
  localparam logic [REV_W-1:0] REV_LAST = REV_W'(REV_N - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        r_state;
  logic              r_ccw;
  logic [STEP_W-1:0] r_remain;
  logic [PRD_W-1:0]  r_reload;
  logic [PRD_W-1:0]  r_cnt;
  logic [REV_W-1:0]  r_rev;

  logic [0:0]        w_state_nxt;
  logic              w_done_nxt;
  logic              w_accept;
  logic              w_fire;
  logic              w_last;
  logic [PRD_W-1:0]  w_qm1;
  logic [1:0]        w_ab_nxt;
  logic [POS_W-1:0]  w_pos_nxt;
  logic [REV_W-1:0]  w_rev_nxt;

  // Next {A,B} in Gray order; CW lets A lead, CCW lets B lead.
  function automatic logic [1:0] f_next_ab(input logic [1:0] ab, input logic ccw);
    logic [1:0] nxt;
    if (ccw) begin
      nxt = {ab[0], ~ab[1]};
    end else begin
      nxt = {~ab[0], ab[1]};
    end
    return nxt;
  endfunction

  assign cmd_ready = ~busy;

  // Handshake, reload value and step-due decode.
  always_comb begin
    w_accept = cmd_valid & (r_state == ST_IDLE);
    w_last   = (r_remain == STEP_W'(1));
    w_fire   = (r_state == ST_RUN) & ~abort & (r_cnt == PRD_W'(0)) & (r_remain != STEP_W'(0));
    if (cmd_qprd == PRD_W'(0)) begin
      w_qm1 = PRD_W'(0);
    end else begin
      w_qm1 = cmd_qprd - PRD_W'(1);
    end
  end

  // Phase, position and revolution index after one edge in the latched direction.
  always_comb begin
    w_ab_nxt = f_next_ab({enc_a, enc_b}, r_ccw);
    if (r_ccw) begin
      w_pos_nxt = pos - POS_W'(1);
      if (r_rev == REV_W'(0)) begin
        w_rev_nxt = REV_LAST;
      end else begin
        w_rev_nxt = r_rev - REV_W'(1);
      end
    end else begin
      w_pos_nxt = pos + POS_W'(1);
      if (r_rev == REV_LAST) begin
        w_rev_nxt = REV_W'(0);
      end else begin
        w_rev_nxt = r_rev + REV_W'(1);
      end
    end
  end

  // FSM next state; abort outranks a step that falls due in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (cmd_steps == STEP_W'(0)) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_fire & w_last) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state with registered busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt == ST_RUN);
      done    <= w_done_nxt;
    end
  end

  // Command latch, remaining-step count and quarter-period down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ccw    <= 1'b0;
      r_remain <= STEP_W'(0);
      r_reload <= PRD_W'(0);
      r_cnt    <= PRD_W'(0);
    end else if (w_accept) begin
      r_ccw    <= cmd_ccw;
      r_remain <= cmd_steps;
      r_reload <= w_qm1;
      r_cnt    <= w_qm1;
    end else if (w_fire) begin
      r_remain <= r_remain - STEP_W'(1);
      r_cnt    <= r_reload;
    end else if ((r_state == ST_RUN) && (r_cnt != PRD_W'(0))) begin
      r_cnt <= r_cnt - PRD_W'(1);
    end
  end

  // Encoder lines and position; phase persists across commands and aborts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_a <= 1'b0;
      enc_b <= 1'b0;
      enc_z <= 1'b1;
      pos   <= POS_W'(0);
      r_rev <= REV_W'(0);
    end else if (w_fire) begin
      enc_a <= w_ab_nxt[1];
      enc_b <= w_ab_nxt[0];
      enc_z <= (w_rev_nxt == REV_W'(0));
      pos   <= w_pos_nxt;
      r_rev <= w_rev_nxt;
    end
  end

endmodule
